// File: rtl/tmp_pkg.sv
// ---------------------------------------------------------------------------
// tmp_pkg
// Shared definitions for the tmp_gen serial pattern source.
//   - state_t     : frame sequencer states
//   - DEF_*       : default parameter values used by tmp_gen and its users
//   - cnt_width() : width of a counter that must hold values 0..n-1 (min 1 bit)
// ---------------------------------------------------------------------------
package tmp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    ACK   = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam int         DEF_DIV     = 4;
  localparam logic [7:0] DEF_PATTERN = 8'hA5;
  localparam int         DEF_NBYTES  = 2;
  localparam int         DEF_GAP     = 2;

  // A counter for n values needs at least one bit even when n == 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tmp_bit_timer.sv
// ---------------------------------------------------------------------------
// tmp_bit_timer
// Free-running divider that marks the last clk cycle of every bit period.
// Ports:
//   clk   in  1  clock, rising edge
//   rst   in  1  synchronous active-high clear (count -> 0)
//   tick  out 1  high while count == DIV-1; the sequencer advances on that edge
// With DIV == 1 the count stays at 0 and tick is permanently high.
// ---------------------------------------------------------------------------
module tmp_bit_timer
  import tmp_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int TW = cnt_width(DIV);

  logic [TW-1:0] count_reg;
  logic [TW-1:0] count_next;

  assign tick = (count_reg == TW'(DIV - 1));

  always_comb begin
    count_next = count_reg + 1'b1;
    if (tick) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/tmp_gen.sv
// ---------------------------------------------------------------------------
// tmp_gen
// Self-running SDA-like pattern source. Emits, forever:
//   GAP idle periods (r=1), START (r=0), NBYTES bytes MSB first each followed
//   by a released ACK slot (r=1), STOP (r=0).
// Byte k of every frame is (PATTERN + k) mod 256.
// Parameters:
//   DIV      clk cycles per bit period (>=1)
//   PATTERN  first data byte of each frame
//   NBYTES   data bytes per frame (>=1)
//   GAP      idle bit periods before each START (>=1)
// Ports:
//   clk  in  1  clock, rising edge
//   rst  in  1  synchronous active-high reset; aborts any frame in progress
//   r    out 1  registered serial output, idle level 1
// ---------------------------------------------------------------------------
module tmp_gen
  import tmp_pkg::*;
#(
  parameter int         DIV     = DEF_DIV,
  parameter logic [7:0] PATTERN = DEF_PATTERN,
  parameter int         NBYTES  = DEF_NBYTES,
  parameter int         GAP     = DEF_GAP
) (
  input  logic clk,
  input  logic rst,
  output logic r
);

  localparam int GW = cnt_width(GAP);
  localparam int IW = cnt_width(NBYTES);

  logic tick;

  state_t        state_reg, state_next;
  logic          r_reg, r_next;
  logic [7:0]    shreg_reg, shreg_next;
  logic [2:0]    bit_reg, bit_next;
  logic [GW-1:0] gap_reg, gap_next;
  logic [IW-1:0] idx_reg, idx_next;

  // Data bytes of the current and the following slot in the frame.
  logic [7:0] byte_cur;
  logic [7:0] byte_nxt;

  assign byte_cur = PATTERN + 8'(idx_reg);
  assign byte_nxt = PATTERN + 8'(idx_reg) + 8'd1;

  tmp_bit_timer #(
    .DIV (DIV)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Sequencer. Everything changes only on the last cycle of a bit period.
  // r_next is the level of the slot being entered, so r is loaded on the
  // same edge as the state and holds for exactly DIV cycles.
  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    shreg_next = shreg_reg;
    bit_next   = bit_reg;
    gap_next   = gap_reg;
    idx_next   = idx_reg;

    if (tick) begin
      unique case (state_reg)
        IDLE: begin
          if (gap_reg == GW'(GAP - 1)) begin
            gap_next   = '0;
            state_next = START;
            r_next     = 1'b0;
          end else begin
            gap_next = gap_reg + 1'b1;
          end
        end

        START: begin
          state_next = DATA;
          shreg_next = byte_cur;
          bit_next   = 3'd7;
          r_next     = byte_cur[7];
        end

        DATA: begin
          if (bit_reg == 3'd0) begin
            state_next = ACK;
            r_next     = 1'b1;
          end else begin
            bit_next = bit_reg - 3'd1;
            r_next   = shreg_reg[bit_reg - 3'd1];
          end
        end

        ACK: begin
          if (idx_reg == IW'(NBYTES - 1)) begin
            state_next = STOP;
            r_next     = 1'b0;
          end else begin
            // Bound by NBYTES-1 above, so the increment cannot overflow.
            idx_next   = idx_reg + 1'b1;
            state_next = DATA;
            shreg_next = byte_nxt;
            bit_next   = 3'd7;
            r_next     = byte_nxt[7];
          end
        end

        STOP: begin
          state_next = IDLE;
          idx_next   = '0;
          gap_next   = '0;
          r_next     = 1'b1;
        end

        default: begin
          state_next = IDLE;
          idx_next   = '0;
          gap_next   = '0;
          r_next     = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      r_reg     <= 1'b1;
      shreg_reg <= '0;
      bit_reg   <= '0;
      gap_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      r_reg     <= r_next;
      shreg_reg <= shreg_next;
      bit_reg   <= bit_next;
      gap_reg   <= gap_next;
      idx_reg   <= idx_next;
    end
  end

  assign r = r_reg;

endmodule

// File: tb/tb_tmp_gen.sv
// ---------------------------------------------------------------------------
// tb_tmp_gen
// Four tmp_gen instances with different parameter sets share clk and rst:
//   0: defaults (DIV4, A5, 2 bytes, GAP2)
//   1: PATTERN=FF (byte wrap FF -> 00)
//   2: DIV1, GAP1, NBYTES1 (12-cycle frame)
//   3: DIV3, PATTERN=FE, NBYTES3, GAP3 (odd divider, wrap inside frame)
// Cycle numbering: cycle c is the value of r sampled on the falling edge
// after c non-reset rising edges following the last reset edge.
// ---------------------------------------------------------------------------
module tb_tmp_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r_def, r_wrap, r_fast, r_odd;

  always #5 clk = ~clk;

  tmp_gen u_def (.clk(clk), .rst(rst), .r(r_def));
  tmp_gen #(.PATTERN(8'hFF)) u_wrap (.clk(clk), .rst(rst), .r(r_wrap));
  tmp_gen #(.DIV(1), .GAP(1), .NBYTES(1)) u_fast (.clk(clk), .rst(rst), .r(r_fast));
  tmp_gen #(.DIV(3), .PATTERN(8'hFE), .NBYTES(3), .GAP(3)) u_odd (.clk(clk), .rst(rst), .r(r_odd));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: r=%b expected %b", name, act, exp);
    end
  endtask

  // Reference: position in the frame is worked out from elapsed cycles alone.
  function automatic logic model_r(input int div, input int pat, input int nb,
                                   input int gap, input int n);
    int len, s, j, b;
    logic [7:0] bv;
    len = gap + 2 + 9 * nb;
    s   = (n / div) % len;
    if (s < gap)      return 1'b1;
    if (s == gap)     return 1'b0;
    if (s == len - 1) return 1'b0;
    j = s - gap - 1;
    b = j % 9;
    if (b == 8) return 1'b1;
    bv = 8'((pat + j / 9) % 256);
    return bv[7 - b];
  endfunction

  int p_div[4] = '{4, 4, 1, 3};
  int p_pat[4] = '{165, 255, 165, 254};
  int p_nb[4]  = '{2, 2, 1, 3};
  int p_gap[4] = '{2, 2, 1, 3};

  logic rr[4];
  assign rr[0] = r_def;
  assign rr[1] = r_wrap;
  assign rr[2] = r_fast;
  assign rr[3] = r_odd;

  // Cycles since the last reset edge.
  int   n = 0;
  logic have_reset = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      n          <= 0;
      have_reset <= 1'b1;
    end else begin
      n <= n + 1;
    end
  end

  // Continuous comparison of every instance against the model.
  always @(negedge clk) begin
    if (have_reset) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("model_dut%0d_n%0d", i, n), rr[i],
              model_r(p_div[i], p_pat[i], p_nb[i], p_gap[i], n));
      end
    end
  end

  typedef struct {
    int   cyc;
    logic exp;
  } vec_t;

  vec_t tab[28];
  logic fast_exp[12];
  logic hist_def[176];
  logic hist_wrap[176];
  logic hist_fast[176];

  task automatic wait_n(input int k, output logic ok);
    ok = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (n == k) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_n: n=%0d expected %0d", n, k);
    end
  endtask

  initial begin
    logic ok;
    logic [7:0] dec;
    logic [7:0] exp_def[2];
    logic [7:0] exp_wrap[2];

    tab = '{
      '{0, 1'b1},  '{7, 1'b1},  '{8, 1'b0},  '{11, 1'b0},
      '{12, 1'b1}, '{16, 1'b0}, '{20, 1'b1}, '{24, 1'b0},
      '{28, 1'b0}, '{32, 1'b1}, '{36, 1'b0}, '{43, 1'b1},
      '{44, 1'b1}, '{47, 1'b1},
      '{48, 1'b1}, '{52, 1'b0}, '{56, 1'b1}, '{60, 1'b0},
      '{64, 1'b0}, '{68, 1'b1}, '{72, 1'b1}, '{79, 1'b0},
      '{80, 1'b1}, '{83, 1'b1}, '{84, 1'b0}, '{87, 1'b0},
      '{86, 1'b0}, '{85, 1'b0}
    };
    fast_exp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_def  = '{8'hA5, 8'hA6};
    exp_wrap = '{8'hFF, 8'h00};

    // Reset asserted and held: r stays at idle level.
    repeat (2) @(posedge clk);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) check($sformatf("reset_hold_dut%0d", i), rr[i], 1'b1);
      $display("reset hold cycle %0d: r=%b%b%b%b", c, rr[0], rr[1], rr[2], rr[3]);
    end

    // Release and record two full default frames.
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 176; c++) begin
      @(negedge clk);
      hist_def[c]  = r_def;
      hist_wrap[c] = r_wrap;
      hist_fast[c] = r_fast;
    end

    for (int e = 0; e < 28; e++) begin
      check($sformatf("frame0_c%0d", tab[e].cyc), hist_def[tab[e].cyc], tab[e].exp);
      check($sformatf("frame1_c%0d", tab[e].cyc + 88), hist_def[tab[e].cyc + 88], tab[e].exp);
      $display("table cycle %0d: r=%b/%b expected %b", tab[e].cyc,
               hist_def[tab[e].cyc], hist_def[tab[e].cyc + 88], tab[e].exp);
    end

    for (int c = 0; c < 24; c++) begin
      check($sformatf("fast_c%0d", c), hist_fast[c], fast_exp[c % 12]);
      $display("fast cycle %0d: r=%b expected %b", c, hist_fast[c], fast_exp[c % 12]);
    end

    // Mid-slot decode of both bytes and ACK slots.
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 8; k++) dec[7 - k] = hist_def[12 + 36 * b + 4 * k + 2];
      n_cmp++;
      if (dec !== exp_def[b]) begin
        n_bad++;
        $display("FAIL decode_def_b%0d: got %h expected %h", b, dec, exp_def[b]);
      end
      $display("decode default byte %0d: %h", b, dec);
      check($sformatf("ack_def_b%0d", b), hist_def[12 + 36 * b + 34], 1'b1);

      for (int k = 0; k < 8; k++) dec[7 - k] = hist_wrap[12 + 36 * b + 4 * k + 2];
      n_cmp++;
      if (dec !== exp_wrap[b]) begin
        n_bad++;
        $display("FAIL decode_wrap_b%0d: got %h expected %h", b, dec, exp_wrap[b]);
      end
      $display("decode wrap byte %0d: %h", b, dec);
      check($sformatf("ack_wrap_b%0d", b), hist_wrap[12 + 36 * b + 34], 1'b1);
    end

    // Reset during DATA bit 3 of the first byte (cycles 28..31 in a frame).
    wait_n(176 + 29, ok);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_r", r_def, 1'b1);
    $display("mid-frame reset: r=%b", r_def);
    for (int c = 1; c < 9; c++) begin
      @(negedge clk);
      check($sformatf("midrst_c%0d", c), r_def, (c == 8) ? 1'b0 : 1'b1);
      $display("after mid-frame reset cycle %0d: r=%b", c, r_def);
    end

    // Random run lengths and reset pulses; the model checker covers every cycle.
    for (int it = 0; it < 25; it++) begin
      int len, hold;
      len  = $urandom_range(1, 250);
      hold = $urandom_range(1, 3);
      repeat (len) @(posedge clk);
      #1 rst = 1'b1;
      repeat (hold) @(posedge clk);
      #1 rst = 1'b0;
      $display("random burst %0d: run %0d cycles, reset %0d cycles", it, len, hold);
    end
    repeat (200) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
